// File: rtl/register_bank_scoreboard.sv
// rtl/register_bank_scoreboard.sv - parametrised register bank with byte-enabled write-back, bypass and busy scoreboard
module register_bank_scoreboard #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NB_REG     = 32,
  parameter int NB_READ    = 2,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          write_enable_i,
  input  logic [ADDR_WIDTH-1:0]         rd_add_i,
  input  logic [DATA_WIDTH-1:0]         rd_data_i,
  input  logic [DATA_WIDTH/8-1:0]       rd_be_i,
  input  logic                          issue_i,
  input  logic [ADDR_WIDTH-1:0]         issue_add_i,
  input  logic [NB_READ*ADDR_WIDTH-1:0] rs_add_i,
  output logic [NB_READ*DATA_WIDTH-1:0] rs_data_o,
  output logic [NB_READ-1:0]            rs_ready_o,
  output logic [NB_REG-1:0]             busy_o
);

  localparam int NB_BYTES = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] NB_REG_W = (ADDR_WIDTH+1)'(NB_REG);

  // An address is backed by real storage only if in range and not the hardwired zero register.
  function automatic logic addr_valid(input logic [ADDR_WIDTH-1:0] a);
    addr_valid = ({1'b0, a} < NB_REG_W) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  logic [DATA_WIDTH-1:0] regs_q [NB_REG];
  logic [DATA_WIDTH-1:0] regs_d [NB_REG];
  logic [NB_REG-1:0]     busy_q;
  logic [NB_REG-1:0]     busy_d;
  logic                  wr_valid;
  logic                  iss_valid;
  logic [DATA_WIDTH-1:0] wr_old;
  logic [DATA_WIDTH-1:0] wr_merged;
  logic [ADDR_WIDTH-1:0] rs_add [NB_READ];

  assign wr_valid  = write_enable_i && addr_valid(rd_add_i);
  assign iss_valid = issue_i && addr_valid(issue_add_i);
  assign busy_o    = busy_q;

  for (genvar p = 0; p < NB_READ; p++) begin : g_rs_add
    assign rs_add[p] = rs_add_i[p*ADDR_WIDTH +: ADDR_WIDTH];
  end

  always_comb begin
    wr_old = '0;
    for (int r = 0; r < NB_REG; r++) begin
      if (rd_add_i == ADDR_WIDTH'(r)) wr_old = regs_q[r];
    end
    wr_merged = wr_old;
    for (int k = 0; k < NB_BYTES; k++) begin
      if (rd_be_i[k]) wr_merged[8*k +: 8] = rd_data_i[8*k +: 8];
    end
  end

  // Issue is applied after write-back so a same-address issue keeps the register busy.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int r = 0; r < NB_REG; r++) begin
      if (wr_valid && (rd_add_i == ADDR_WIDTH'(r))) begin
        regs_d[r] = wr_merged;
        busy_d[r] = 1'b0;
      end
      if (iss_valid && (issue_add_i == ADDR_WIDTH'(r))) busy_d[r] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NB_REG; r++) regs_q[r] <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    rs_data_o  = '0;
    rs_ready_o = '1;
    for (int p = 0; p < NB_READ; p++) begin
      if (addr_valid(rs_add[p])) begin
        for (int r = 0; r < NB_REG; r++) begin
          if (rs_add[p] == ADDR_WIDTH'(r)) begin
            rs_data_o[p*DATA_WIDTH +: DATA_WIDTH] = regs_q[r];
            rs_ready_o[p] = ~busy_q[r];
          end
        end
        if ((BYPASS != 0) && wr_valid && (rd_add_i == rs_add[p])) begin
          rs_data_o[p*DATA_WIDTH +: DATA_WIDTH] = wr_merged;
          rs_ready_o[p] = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_register_bank_scoreboard.sv
// tb/tb_register_bank_scoreboard.sv - randomized self-checking bench for register_bank_scoreboard
module tb_register_bank_scoreboard;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 28;
  localparam int NP = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, we, issue;
  logic [AW-1:0]    rd_add, issue_add;
  logic [DW-1:0]    rd_data;
  logic [DW/8-1:0]  be;
  logic [NP*AW-1:0] rs_add;
  logic [NP*DW-1:0] rs_data_a, rs_data_b;
  logic [NP-1:0]    rdy_a, rdy_b;
  logic [NR-1:0]    busy_a, busy_b;

  register_bank_scoreboard #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NB_REG(NR), .NB_READ(NP),
                             .BYPASS(1), .ZERO_REG(1)) u_dut (
    .clk_i(clk), .rst_i(rst), .write_enable_i(we), .rd_add_i(rd_add), .rd_data_i(rd_data),
    .rd_be_i(be), .issue_i(issue), .issue_add_i(issue_add), .rs_add_i(rs_add),
    .rs_data_o(rs_data_a), .rs_ready_o(rdy_a), .busy_o(busy_a));

  register_bank_scoreboard #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NB_REG(NR), .NB_READ(NP),
                             .BYPASS(0), .ZERO_REG(1)) u_dut_nobyp (
    .clk_i(clk), .rst_i(rst), .write_enable_i(we), .rd_add_i(rd_add), .rd_data_i(rd_data),
    .rd_be_i(be), .issue_i(issue), .issue_add_i(issue_add), .rs_add_i(rs_add),
    .rs_data_o(rs_data_b), .rs_ready_o(rdy_b), .busy_o(busy_b));

  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0] mem [NR];
  bit            bsy [NR];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic bit legal(input int a);
    return (a != 0) && (a < NR);
  endfunction

  function automatic logic [DW-1:0] merged(input int a);
    logic [DW-1:0] v;
    v = mem[a];
    for (int k = 0; k < DW/8; k++) if (be[k]) v[8*k +: 8] = rd_data[8*k +: 8];
    return v;
  endfunction

  // Returns {ready, data} as decode should see it this cycle.
  function automatic logic [DW:0] expect_read(input int a, input bit byp);
    if (!legal(a)) return {1'b1, {DW{1'b0}}};
    if (byp && we && (int'(rd_add) == a)) return {1'b1, merged(a)};
    return {~bsy[a], mem[a]};
  endfunction

  task automatic set_idle;
    rst = 0; we = 0; issue = 0; rd_add = '0; issue_add = '0; rd_data = '0; be = '0; rs_add = '0;
  endtask

  task automatic settle(input string tag);
    logic [DW:0]   e;
    logic [NR-1:0] eb;
    @(negedge clk);
    for (int p = 0; p < NP; p++) begin
      e = expect_read(int'(rs_add[p*AW +: AW]), 1'b1);
      check($sformatf("%s_byp_data%0d", tag, p), 64'(rs_data_a[p*DW +: DW]), 64'(e[DW-1:0]));
      check($sformatf("%s_byp_rdy%0d", tag, p), 64'(rdy_a[p]), 64'(e[DW]));
      e = expect_read(int'(rs_add[p*AW +: AW]), 1'b0);
      check($sformatf("%s_nob_data%0d", tag, p), 64'(rs_data_b[p*DW +: DW]), 64'(e[DW-1:0]));
      check($sformatf("%s_nob_rdy%0d", tag, p), 64'(rdy_b[p]), 64'(e[DW]));
    end
    for (int i = 0; i < NR; i++) eb[i] = bsy[i];
    check({tag, "_busy"}, 64'(busy_a), 64'(eb));
    check({tag, "_busy_nob"}, 64'(busy_b), 64'(eb));
  endtask

  task automatic clk_edge;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < NR; i++) begin mem[i] = '0; bsy[i] = 0; end
    end else begin
      if (we && legal(int'(rd_add))) begin
        mem[rd_add] = merged(int'(rd_add));
        bsy[rd_add] = 0;
      end
      if (issue && legal(int'(issue_add))) bsy[issue_add] = 1;
    end
    #1;
  endtask

  task automatic write(input int a, input logic [DW-1:0] d, input logic [DW/8-1:0] b);
    we = 1; rd_add = AW'(a); rd_data = d; be = b;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin mem[i] = 'x; bsy[i] = 0; end
    set_idle();
    rst = 1;
    clk_edge();
    set_idle();
    rs_add = {AW'(3), AW'(0)};
    settle("reset");
    check("reset_rdy_all", 64'(rdy_a), 64'(2'b11));
    check("reset_busy_zero", 64'(busy_a), 64'h0);
    clk_edge();

    write(1, 32'h1111_1111, 4'hF);
    settle("wr_x1");
    clk_edge();
    set_idle(); rs_add = {AW'(31), AW'(1)};
    settle("rd_x1");
    check("x1_value", 64'(rs_data_a[31:0]), 64'h1111_1111);
    check("x31_out_of_range", 64'(rs_data_a[63:32]), 64'h0);
    clk_edge();

    write(3, 32'hAABB_CCDD, 4'hF);
    settle("wr_x3");
    clk_edge();
    write(3, 32'h2222_2222, 4'b0101); rs_add = {AW'(0), AW'(3)};
    settle("wr_x3_be");
    clk_edge();
    set_idle(); rs_add = {AW'(0), AW'(3)};
    settle("rd_x3");
    check("x3_byte_merge", 64'(rs_data_a[31:0]), 64'hAA22_CC22);
    clk_edge();

    write(4, 32'h3333_3333, 4'hF); rs_add = {AW'(4), AW'(0)};
    settle("bypass_x4");
    check("bypass_data", 64'(rs_data_a[63:32]), 64'h3333_3333);
    check("bypass_rdy", 64'(rdy_a[1]), 64'h1);
    check("nobypass_old", 64'(rs_data_b[63:32]), 64'h0);
    clk_edge();

    set_idle(); issue = 1; issue_add = 5;
    settle("issue_x5");
    clk_edge();
    set_idle(); rs_add = {AW'(0), AW'(5)};
    settle("busy_x5_a");
    check("x5_busy", 64'(busy_a[5]), 64'h1);
    check("x5_not_ready", 64'(rdy_a[0]), 64'h0);
    clk_edge();
    settle("busy_x5_b");
    clk_edge();
    write(5, 32'h5555_5555, 4'hF);
    settle("wb_x5");
    check("x5_wb_ready_byp", 64'(rdy_a[0]), 64'h1);
    check("x5_wb_ready_nob", 64'(rdy_b[0]), 64'h0);
    clk_edge();
    set_idle();
    settle("after_wb_x5");
    check("x5_busy_clear", 64'(busy_a[5]), 64'h0);
    clk_edge();

    write(6, 32'h6666_6666, 4'hF); issue = 1; issue_add = 6;
    settle("iss_wb_x6");
    clk_edge();
    set_idle(); issue = 1; issue_add = 0;
    settle("iss_x0");
    check("x6_busy_kept", 64'(busy_a[6]), 64'h1);
    clk_edge();
    set_idle(); write(0, 32'hFFFF_FFFF, 4'hF);
    settle("wr_x0");
    check("x0_never_busy", 64'(busy_a[0]), 64'h0);
    clk_edge();
    set_idle();
    settle("rd_x0");
    check("x0_reads_zero", 64'(rs_data_a[31:0]), 64'h0);
    clk_edge();

    write(1, 32'h1111_1111, 4'hF); issue = 1; issue_add = 7;
    settle("pre_rst");
    clk_edge();
    set_idle(); rst = 1; write(1, 32'h9999_9999, 4'hF);
    settle("rst_with_wr");
    clk_edge();
    set_idle(); rs_add = {AW'(7), AW'(1)};
    settle("post_rst");
    check("rst_x1_zero", 64'(rs_data_a[31:0]), 64'h0);
    check("rst_busy_zero", 64'(busy_a), 64'h0);
    clk_edge();

    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 99) < 2);
      we        = ($urandom_range(0, 1) == 1);
      rd_add    = AW'($urandom_range(0, 31));
      rd_data   = $urandom;
      be        = DW'($urandom) >> (DW - DW/8);
      issue     = ($urandom_range(0, 9) < 3);
      issue_add = ($urandom_range(0, 1) == 1) ? rd_add : AW'($urandom_range(0, 31));
      rs_add[AW-1:0]    = ($urandom_range(0, 2) == 0) ? rd_add : AW'($urandom_range(0, 31));
      rs_add[2*AW-1:AW] = ($urandom_range(0, 3) == 0) ? rs_add[AW-1:0] : AW'($urandom_range(0, 31));
      settle("rand");
      clk_edge();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/register_bank_scoreboard.md
Name: register_bank_scoreboard

Overview:
- Parametrised successor of the core register bank for the pipelined RISC-V datapath.
- Provides configurable register count and width, N combinational read ports, byte-enabled write-back and write-to-read bypass.
- Adds an x0 hardwired-zero option and a per-register busy scoreboard, so decode can detect pending write-backs.

Parameters:
- DATA_WIDTH, 32, register width in bits; must be a multiple of 8.
- ADDR_WIDTH, 5, register address width.
- NB_REG, 32, number of registers; NB_REG <= 2**ADDR_WIDTH.
- NB_READ, 2, number of read ports; range 1..4.
- BYPASS, 1, 1 = same-cycle write data is forwarded to the read ports.
- ZERO_REG, 1, 1 = register 0 is hardwired to zero and never busy.

Ports:
- clk_i  in  1  system clock; all state updates on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- write_enable_i  in  1  write-back strobe.
- rd_add_i  in  ADDR_WIDTH  write-back address.
- rd_data_i  in  DATA_WIDTH  write-back data.
- rd_be_i  in  DATA_WIDTH/8  write byte enables; bit k covers bits [8k+7:8k].
- issue_i  in  1  marks issue_add_i as pending (sets its busy bit).
- issue_add_i  in  ADDR_WIDTH  destination register of the instruction being issued.
- rs_add_i  in  NB_READ*ADDR_WIDTH  packed read addresses; port p uses slice p.
- rs_data_o  out  NB_READ*DATA_WIDTH  packed read data.
- rs_ready_o  out  NB_READ  1 = port p data is final (no pending write).
- busy_o  out  NB_REG  raw scoreboard bits.

Behaviour:
Reset
- Reset is synchronous and active-high: on a rising clk_i edge with rst_i=1, all registers clear to 0 and all busy bits clear to 0.
- Reset has priority over write_enable_i and issue_i in the same cycle.
- Outputs after reset: rs_data_o=0, rs_ready_o all 1, busy_o=0.

Write
- On a rising edge with write_enable_i=1 and a legal rd_add_i, each byte with rd_be_i[k]=1 takes rd_data_i; bytes with rd_be_i[k]=0 keep their old value.
- Write latency: 1 cycle to storage.
- A write with rd_be_i=0 leaves the data unchanged but still clears the busy bit.

Read
- Combinational; 0-cycle latency from rs_add_i.
- Address >= NB_REG: rs_data=0, rs_ready=1.
- With ZERO_REG=1, address 0: rs_data=0, rs_ready=1.

Bypass (BYPASS=1)
- Applies when write_enable_i=1, rd_add_i equals the read address, and the address is legal and non-zero-reg.
- rs_data then equals the byte-merged value the register will hold after the edge, and rs_ready=1.
- With BYPASS=0, reads show the stored value only; the written value is visible the cycle after.

Scoreboard
- issue_i=1 sets busy[issue_add_i]; a write-back clears busy[rd_add_i].
- Issue and write-back to the same address in the same cycle: busy stays 1 (the new issue wins).
- Issue and write-back to different addresses in the same cycle: both take effect.
- Issue to register 0 (with ZERO_REG=1) or to an address >= NB_REG is ignored.
- Without bypass: rs_ready[p] = ~busy[rs_add_p].

Ignored writes and multi-port rules
- Writes to register 0 (with ZERO_REG=1) or to an address >= NB_REG change no state.
- Multiple read ports may use the same address and all return identical values.

Test Plan:
1. Reset, then write 0x11111111 to x1 with all byte enables and read port 0 at x1 in the next cycle -> 0x11111111, ready=1. Read x0 and x31 -> 0.
2. x3=0xAABBCCDD, then write 0x22222222 with rd_be_i=4'b0101 -> x3 reads 0xAA22CC22.
3. BYPASS=1: write 0x33333333 to x4 while port 1 reads x4 in the same cycle -> rs_data=0x33333333 and rs_ready=1 before the edge. With BYPASS=0 the same cycle shows the old value.
4. Issue x5 -> busy_o[5]=1 and a read of x5 shows ready=0. Write back x5 two cycles later -> ready=1 in the write cycle with bypass, and busy_o[5]=0 after the edge.
5. Issue x6 and write back x6 in the same cycle -> busy_o[6] stays 1. Issue x0 -> busy_o[0] stays 0. Write 0xFFFFFFFF to x0 -> x0 still reads 0.
6. Set x1=0x11111111 and busy[7]=1, then assert rst_i with write_enable_i=1 to x1 (0x99999999) in the same cycle -> x1=0 and busy_o=0 after the edge.
